// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Optional immediate range checking is enabled by IMM_RANGE_CHECK_EN.
package riscv_enc_pkg;

  typedef enum logic [4:0] {
    MN_ADD    = 5'd0,
    MN_SUB    = 5'd1,
    MN_AND    = 5'd2,
    MN_OR     = 5'd3,
    MN_XOR    = 5'd4,
    MN_SLT    = 5'd5,
    MN_SLTU   = 5'd6,
    MN_ADDI   = 5'd7,
    MN_ORI    = 5'd8,
    MN_XORI   = 5'd9,
    MN_ANDI   = 5'd10,
    MN_SLTI   = 5'd11,
    MN_SLTIU  = 5'd12,
    MN_SLLI   = 5'd13,
    MN_LW     = 5'd14,
    MN_JALR   = 5'd15,
    MN_SW     = 5'd16,
    MN_BEQ    = 5'd17,
    MN_BNE    = 5'd18,
    MN_JAL    = 5'd19,
    MN_LUI    = 5'd20,
    MN_AUIPC  = 5'd21,
    MN_ECALL  = 5'd22,
    MN_EBREAK = 5'd23
  } mnem_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SH,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U,
    FMT_SYS
  } fmt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_SYS   = 7'h73;

  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
  localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational mnemonic + fields -> RV32I word, illegal and range flags.
// Range flag is only produced when IMM_RANGE_CHECK_EN is defined.
module instr_pack
  import riscv_enc_pkg::*;
(
  input  logic [4:0]  i_mnem,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal,
  output logic        o_range_err
);

  fmt_t        w_fmt;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_sys;

  // mnemonic -> format, opcode and function fields
  always_comb begin
    w_fmt     = FMT_SYS;
    w_op      = OP_SYS;
    w_f3      = 3'd0;
    w_f7      = 7'd0;
    w_sys     = NOP_WORD;
    o_illegal = 1'b0;
    case (i_mnem)
      MN_ADD:    begin w_fmt = FMT_R; w_op = OP_R; end
      MN_SUB:    begin
        w_fmt = FMT_R; w_op = OP_R; w_f7 = 7'h20;
      end
      MN_AND:    begin w_fmt = FMT_R; w_op = OP_R; w_f3 = 3'd7; end
      MN_OR:     begin w_fmt = FMT_R; w_op = OP_R; w_f3 = 3'd6; end
      MN_XOR:    begin w_fmt = FMT_R; w_op = OP_R; w_f3 = 3'd4; end
      MN_SLT:    begin w_fmt = FMT_R; w_op = OP_R; w_f3 = 3'd2; end
      MN_SLTU:   begin w_fmt = FMT_R; w_op = OP_R; w_f3 = 3'd3; end
      MN_ADDI:   begin w_fmt = FMT_I; w_op = OP_I; end
      MN_ORI:    begin w_fmt = FMT_I; w_op = OP_I; w_f3 = 3'd6; end
      MN_XORI:   begin w_fmt = FMT_I; w_op = OP_I; w_f3 = 3'd4; end
      MN_ANDI:   begin w_fmt = FMT_I; w_op = OP_I; w_f3 = 3'd7; end
      MN_SLTI:   begin w_fmt = FMT_I; w_op = OP_I; w_f3 = 3'd2; end
      MN_SLTIU:  begin w_fmt = FMT_I; w_op = OP_I; w_f3 = 3'd3; end
      MN_SLLI:   begin w_fmt = FMT_SH; w_op = OP_I; w_f3 = 3'd1; end
      MN_LW:     begin w_fmt = FMT_I; w_op = OP_LOAD; w_f3 = 3'd2; end
      MN_JALR:   begin w_fmt = FMT_I; w_op = OP_JALR; end
      MN_SW:     begin w_fmt = FMT_S; w_op = OP_S; w_f3 = 3'd2; end
      MN_BEQ:    begin w_fmt = FMT_B; w_op = OP_B; end
      MN_BNE:    begin w_fmt = FMT_B; w_op = OP_B; w_f3 = 3'd1; end
      MN_JAL:    begin w_fmt = FMT_J; w_op = OP_JAL; end
      MN_LUI:    begin w_fmt = FMT_U; w_op = OP_LUI; end
      MN_AUIPC:  begin w_fmt = FMT_U; w_op = OP_AUIPC; end
      MN_ECALL:  w_sys = ECALL_WORD;
      MN_EBREAK: w_sys = EBREAK_WORD;
      default:   o_illegal = 1'b1;
    endcase
  end

  // pack fields into the format's bit layout; B/J drop imm[0]
  always_comb begin
    o_word = w_sys;
    unique case (w_fmt)
      FMT_R:  o_word = {w_f7, i_rs2, i_rs1, w_f3, i_rd, w_op};
      FMT_I:  o_word = {i_imm[11:0], i_rs1, w_f3, i_rd, w_op};
      FMT_SH: o_word = {7'd0, i_imm[4:0], i_rs1, w_f3, i_rd, w_op};
      FMT_S:  o_word = {i_imm[11:5], i_rs2, i_rs1, w_f3,
                        i_imm[4:0], w_op};
      FMT_B:  o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                        i_imm[4:1], i_imm[11], w_op};
      FMT_J:  o_word = {i_imm[20], i_imm[10:1], i_imm[11],
                        i_imm[19:12], i_rd, w_op};
      FMT_U:  o_word = {i_imm[31:12], i_rd, w_op};
      FMT_SYS: o_word = w_sys;
      default: o_word = w_sys;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // immediate must be representable in its format
  always_comb begin
    o_range_err = 1'b0;
    case (w_fmt)
      FMT_I, FMT_S:
        o_range_err = !(&i_imm[31:11] || ~|i_imm[31:11]);
      FMT_B:
        o_range_err = !(&i_imm[31:12] || ~|i_imm[31:12])
                      || i_imm[0];
      FMT_J:
        o_range_err = !(&i_imm[31:20] || ~|i_imm[31:20])
                      || i_imm[0];
      FMT_U:  o_range_err = |i_imm[11:0];
      FMT_SH: o_range_err = |i_imm[31:5];
      default: o_range_err = 1'b0;
    endcase
  end
`else
  assign o_range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes mnemonic requests and writes them to instr memory.
// Define IMM_RANGE_CHECK_EN to flag immediates that do not fit their format.
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_mnem,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_last,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] instr_count,
  output logic                  err,
  output logic [1:0]            err_code
);

  state_t      r_state;
  state_t      w_next;
  logic        w_acc;
  logic        w_cmp;
  logic        w_start;
  logic [31:0] w_word;
  logic        w_ill;
  logic        w_rng;

  instr_pack u_pack (
    .i_mnem      (in_mnem),
    .i_rd        (in_rd),
    .i_rs1       (in_rs1),
    .i_rs2       (in_rs2),
    .i_imm       (in_imm),
    .o_word      (w_word),
    .o_illegal   (w_ill),
    .o_range_err (w_rng)
  );

  assign in_ready = (r_state == ST_LOAD) && (!wr_en || wr_ready);
  assign w_acc    = in_valid && in_ready;
  assign w_cmp    = wr_en && wr_ready;
  assign w_start  = start && (r_state == ST_IDLE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // next state and status outputs
  always_comb begin
    w_next = r_state;
    busy   = (r_state != ST_IDLE);
    done   = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  if (w_acc && in_last) w_next = ST_DRAIN;
      ST_DRAIN: if (w_cmp) w_next = ST_DONE;
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // output register, address/count advance, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      instr_count <= '0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else if (w_start) begin
      wr_addr     <= base_addr;
      instr_count <= '0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      if (w_cmp) begin
        wr_addr     <= wr_addr + ADDR_WIDTH'(4);
        instr_count <= instr_count + ADDR_WIDTH'(1);
      end
      if (w_acc) begin
        wr_en   <= 1'b1;
        wr_data <= DATA_WIDTH'(w_word);
        if (!err && (w_ill || w_rng)) begin
          err      <= 1'b1;
          err_code <= w_ill ? ERR_ILLEGAL : ERR_RANGE;
        end
      end else if (w_cmp) begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus random programs
// checked every cycle against a behavioural model.
module tb_instr_encoder;
  import riscv_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_mnem = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        wr_en;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] instr_count;
  logic        err;
  logic [1:0]  err_code;

  bit rdy_rand = 1'b0;
  bit rdy_force = 1'b1;
  bit rnd_bit = 1'b1;
  assign wr_ready = rdy_rand ? rnd_bit : rdy_force;

  int n_chk = 0;
  int n_err = 0;

  instr_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .wr_en(wr_en), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .instr_count(instr_count), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int K_R = 0, K_I = 1, K_SH = 2, K_S = 3;
  localparam int K_B = 4, K_J = 5, K_U = 6, K_SYS = 7;

  function automatic logic [31:0] ref_enc(
      input logic [4:0] m, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm,
      output bit ill, output bit rng);
    int k, f3, f7, op;
    longint si;
    logic [31:0] w, r1, r2, d;
    k = K_SYS; f3 = 0; f7 = 0; op = 'h73; ill = 0; rng = 0;
    w = 32'h13;
    si = longint'($signed(imm));
    r1 = 32'(rs1) << 15; r2 = 32'(rs2) << 20; d = 32'(rd) << 7;
    case (m)
      MN_ADD:  begin k = K_R; op = 'h33; end
      MN_SUB:  begin k = K_R; op = 'h33; f7 = 32; end
      MN_AND:  begin k = K_R; op = 'h33; f3 = 7; end
      MN_OR:   begin k = K_R; op = 'h33; f3 = 6; end
      MN_XOR:  begin k = K_R; op = 'h33; f3 = 4; end
      MN_SLT:  begin k = K_R; op = 'h33; f3 = 2; end
      MN_SLTU: begin k = K_R; op = 'h33; f3 = 3; end
      MN_ADDI: begin k = K_I; op = 'h13; end
      MN_ORI:  begin k = K_I; op = 'h13; f3 = 6; end
      MN_XORI: begin k = K_I; op = 'h13; f3 = 4; end
      MN_ANDI: begin k = K_I; op = 'h13; f3 = 7; end
      MN_SLTI: begin k = K_I; op = 'h13; f3 = 2; end
      MN_SLTIU: begin k = K_I; op = 'h13; f3 = 3; end
      MN_SLLI: begin k = K_SH; op = 'h13; f3 = 1; end
      MN_LW:   begin k = K_I; op = 'h03; f3 = 2; end
      MN_JALR: begin k = K_I; op = 'h67; end
      MN_SW:   begin k = K_S; op = 'h23; f3 = 2; end
      MN_BEQ:  begin k = K_B; op = 'h63; end
      MN_BNE:  begin k = K_B; op = 'h63; f3 = 1; end
      MN_JAL:  begin k = K_J; op = 'h6F; end
      MN_LUI:  begin k = K_U; op = 'h37; end
      MN_AUIPC: begin k = K_U; op = 'h17; end
      MN_ECALL: w = 32'h73;
      MN_EBREAK: w = 32'h0010_0073;
      default: ill = 1;
    endcase
    case (k)
      K_R: w = (32'(f7) << 25) | r2 | r1 | (32'(f3) << 12) | d | 32'(op);
      K_I: begin
        w = ((imm & 32'hFFF) << 20) | r1 | (32'(f3) << 12) | d | 32'(op);
        rng = (si < -2048) || (si > 2047);
      end
      K_SH: begin
        w = ((imm & 32'h1F) << 20) | r1 | (32'(f3) << 12) | d | 32'(op);
        rng = (imm > 32'd31);
      end
      K_S: begin
        w = (((imm >> 5) & 32'h7F) << 25) | r2 | r1 | (32'(f3) << 12)
            | ((imm & 32'h1F) << 7) | 32'(op);
        rng = (si < -2048) || (si > 2047);
      end
      K_B: begin
        w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
            | r2 | r1 | (32'(f3) << 12) | (((imm >> 1) & 32'hF) << 8)
            | (((imm >> 11) & 1) << 7) | 32'(op);
        rng = (si < -4096) || (si > 4095) || (imm % 2 != 0);
      end
      K_J: begin
        w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
            | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
            | d | 32'(op);
        rng = (si < -1048576) || (si > 1048575) || (imm % 2 != 0);
      end
      K_U: begin
        w = (imm & 32'hFFFF_F000) | d | 32'(op);
        rng = (imm % 4096 != 0);
      end
      default: ;
    endcase
`ifndef IMM_RANGE_CHECK_EN
    rng = 0;
`endif
    return w;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          m_phase = 0;   // 0 idle, 1 load, 2 drain, 3 done
  logic [31:0] m_base = '0;
  logic [31:0] m_count = '0;
  logic [31:0] m_nacc = '0;
  bit          m_err = 0;
  logic [1:0]  m_code = '0;

  // per-cycle compare and model advance
  always @(negedge clk) begin
    bit acc, cmp, ill, rng;
    int np;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_phase = 0; m_count = 0; m_nacc = 0; m_err = 0; m_code = 0;
    end else begin
      chk("mon_wr_en", 32'(wr_en), 32'(q.size() != 0));
      if (wr_en && q.size() != 0) begin
        chk("mon_wr_addr", wr_addr, q[0].a);
        chk("mon_wr_data", wr_data, q[0].d);
      end
      chk("mon_in_ready", 32'(in_ready),
          32'(m_phase == 1 && (q.size() == 0 || wr_ready)));
      chk("mon_busy", 32'(busy), 32'(m_phase != 0));
      chk("mon_done", 32'(done), 32'(m_phase == 3));
      chk("mon_count", instr_count, m_count);
      chk("mon_err", 32'(err), 32'(m_err));
      chk("mon_err_code", 32'(err_code), 32'(m_code));
      acc = in_valid && in_ready && m_phase == 1;
      cmp = wr_en && wr_ready && q.size() != 0;
      np = m_phase;
      if (cmp) begin
        q.delete(0);
        m_count++;
        if (m_phase == 2) np = 3;
      end
      if (acc) begin
        e.d = ref_enc(in_mnem, in_rd, in_rs1, in_rs2, in_imm, ill, rng);
        e.a = m_base + 32'd4 * m_nacc;
        q.push_back(e);
        m_nacc++;
        if (!m_err && (ill || rng)) begin
          m_err = 1;
          m_code = ill ? 2'b01 : 2'b10;
        end
        if (in_last) np = 2;
      end
      if (m_phase == 0 && start) begin
        np = 1; m_base = base_addr;
        m_count = 0; m_nacc = 0; m_err = 0; m_code = 0;
      end
      if (m_phase == 3) np = 0;
      m_phase = np;
    end
  end

  // ---------------- drivers ----------------
  task automatic start_prog(input logic [31:0] b);
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] m, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit last,
                      output int waited);
    int k;
    in_mnem = m; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last; in_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    waited = k;
    if (k >= 200) chk("send_timeout", 32'(k), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", 32'(k < 200), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic one(input string nm, input logic [4:0] m,
                     input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm,
                     input logic [31:0] exp, input logic [31:0] b);
    int w;
    start_prog(b);
    send(m, rd, rs1, rs2, imm, 1'b1, w);
    in_valid = 1'b0;
    chk({nm, "_data"}, wr_data, exp);
    chk({nm, "_addr"}, wr_addr, b);
    chk({nm, "_en"}, 32'(wr_en), 32'd1);
  endtask

  function automatic logic [31:0] rnd_imm();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 4095)) - 32'd2048;
      1: return $urandom;
      2: return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      3: return $urandom & 32'hFFFF_F000;
      default: return 32'($urandom_range(0, 40));
    endcase
  endfunction

  initial begin
    int w, len, gap;
    logic [4:0] m;
    logic [31:0] b;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    one("addi", MN_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 32'h100);
    wait_done();
    chk("addi_count", instr_count, 32'd1);

    start_prog(32'h100);
    send(MN_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, w);
    chk("add_data", wr_data, 32'h0020_81B3);
    chk("add_addr", wr_addr, 32'h100);
    send(MN_SW, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, w);
    in_valid = 1'b0;
    chk("sw_nobubble", 32'(w), 32'd0);
    chk("sw_data", wr_data, 32'h0020_A423);
    chk("sw_addr", wr_addr, 32'h104);
    wait_done();
    chk("sw_count", instr_count, 32'd2);

    one("beq", MN_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 32'h40);
    wait_done();
    one("lui", MN_LUI, 5'd5, 5'd0, 5'd0, 32'h1234_5000,
        32'h1234_52B7, 32'h80);
    wait_done();
    one("jal", MN_JAL, 5'd1, 5'd0, 5'd0, 32'd16, 32'h0100_00EF, 32'hC0);
    wait_done();
    chk("jal_count", instr_count, 32'd1);

    // stall for three cycles with a request waiting
    start_prog(32'h200);
    send(MN_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, w);
    rdy_force = 1'b0;
    in_mnem = MN_ADD; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2;
    in_imm = 32'd0; in_last = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_data", wr_data, 32'h0050_0093);
      chk("stall_addr", wr_addr, 32'h200);
    end
    @(posedge clk); #1;
    rdy_force = 1'b1;
    send(MN_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, w);
    in_valid = 1'b0;
    chk("resume_data", wr_data, 32'h0020_81B3);
    chk("resume_addr", wr_addr, 32'h204);
    wait_done();
    chk("resume_count", instr_count, 32'd2);

    one("addi800", MN_ADDI, 5'd1, 5'd0, 5'd0, 32'h800,
        32'h8000_0093, 32'h300);
`ifdef IMM_RANGE_CHECK_EN
    chk("addi800_err", 32'(err), 32'd1);
    chk("addi800_code", 32'(err_code), 32'd2);
`else
    chk("addi800_err", 32'(err), 32'd0);
    chk("addi800_code", 32'(err_code), 32'd0);
`endif
    wait_done();

    one("illegal", 5'h1F, 5'd1, 5'd2, 5'd3, 32'd7, 32'h0000_0013, 32'h340);
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_code", 32'(err_code), 32'd1);
    wait_done();

    // asynchronous reset with a write pending
    start_prog(32'h400);
    rdy_force = 1'b0;
    send(MN_ADDI, 5'd2, 5'd0, 5'd0, 32'd9, 1'b0, w);
    in_valid = 1'b0;
    chk("prerst_wr_en", 32'(wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", wr_addr, 32'd0);
    rdy_force = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // random programs under random backpressure
    rdy_rand = 1'b1;
    for (int p = 0; p < 40; p++) begin
      b = (p % 8 == 3) ? 32'hFFFF_FFF8 : ($urandom & ~32'd3);
      start_prog(b);
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        gap = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (gap) begin
          start = ($urandom_range(0, 3) == 0);
          base_addr = $urandom;
          @(posedge clk); #1;
        end
        start = 1'b0;
        if ($urandom_range(0, 9) == 0) m = 5'($urandom_range(24, 31));
        else m = 5'($urandom_range(0, 23));
        send(m, 5'($urandom), 5'($urandom), 5'($urandom), rnd_imm(),
             (i == len - 1), w);
      end
      in_valid = 1'b0;
      wait_done();
    end
    rdy_rand = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
